// File: rtl/edge_list_fetch.sv
// CSR graph store that streams one node's successors per expand request.
// Header RAM holds {base, degree}; edge RAM holds successor indices.
module edge_list_fetch #(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_COUNTER_WIDTH   = 4,
  parameter int PARAM_EDGE_ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hdr_we,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  hdr_node,
  input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] hdr_base,
  input  logic [PARAM_COUNTER_WIDTH-1:0]   hdr_deg,
  input  logic                             edge_we,
  input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] edge_addr,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  edge_succ,
  input  logic                             node_req,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  node_idx_reg,
  output logic                             req_ready,
  output logic                             next_node_valid,
  input  logic                             rd_next_node_reg,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter,
  output logic                             node_empty,
  output logic                             load_drop
);

  localparam int NW = PARAM_NODE_IDX_WIDTH;
  localparam int CW = PARAM_COUNTER_WIDTH;
  localparam int AW = PARAM_EDGE_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FETCH,
    S_PRESENT
  } state_e;

  logic [AW-1:0] hdr_base_mem [2**NW];
  logic [CW-1:0] hdr_deg_mem  [2**NW];
  logic [NW-1:0] edge_mem     [2**AW];

  state_e        state_q, state_d;
  logic [AW-1:0] hdr_base_rd_q;
  logic [CW-1:0] hdr_deg_rd_q;
  logic [NW-1:0] edge_rd_q;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          empty_q, empty_d;
  logic          drop_q, drop_d;

  logic          hdr_re;
  logic          edge_re;
  logic [AW-1:0] edge_raddr;
  logic          idle;

  assign idle = (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    empty_d    = 1'b0;
    drop_d     = drop_q | ((hdr_we | edge_we) & ~idle);
    hdr_re     = 1'b0;
    edge_re    = 1'b0;
    edge_raddr = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (node_req) begin
          hdr_re  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hdr_deg_rd_q == '0) begin
          empty_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          ptr_d      = hdr_base_rd_q;
          rem_d      = hdr_deg_rd_q - CW'(1);
          edge_re    = 1'b1;
          edge_raddr = hdr_base_rd_q;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        idx_d   = edge_rd_q;
        cnt_d   = rem_q;
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (rd_next_node_reg) begin
          valid_d = 1'b0;
          if (rem_q == '0) begin
            state_d = S_IDLE;
          end else begin
            // pointer wraps naturally at the top of the edge RAM
            ptr_d      = ptr_q + AW'(1);
            rem_d      = rem_q - CW'(1);
            edge_re    = 1'b1;
            edge_raddr = ptr_q + AW'(1);
            state_d    = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hdr_we && idle) begin
      hdr_base_mem[hdr_node] <= hdr_base;
      hdr_deg_mem[hdr_node]  <= hdr_deg;
    end
    if (edge_we && idle) begin
      edge_mem[edge_addr] <= edge_succ;
    end
    if (hdr_re) begin
      hdr_base_rd_q <= hdr_base_mem[node_idx_reg];
      hdr_deg_rd_q  <= hdr_deg_mem[node_idx_reg];
    end
    if (edge_re) begin
      edge_rd_q <= edge_mem[edge_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      drop_q  <= drop_d;
    end
  end

  assign req_ready         = idle;
  assign next_node_valid   = valid_q;
  assign next_node_idx     = idx_q;
  assign next_node_counter = cnt_q;
  assign node_empty        = empty_q;
  assign load_drop         = drop_q;

endmodule

// File: tb/tb_edge_list_fetch.sv
// Bench for edge_list_fetch: directed scenarios plus a CSR model
// that predicts every presented successor.
module tb_edge_list_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_we = 1'b0;
  logic [9:0]  hdr_node = '0;
  logic [11:0] hdr_base = '0;
  logic [3:0]  hdr_deg = '0;
  logic        edge_we = 1'b0;
  logic [11:0] edge_addr = '0;
  logic [9:0]  edge_succ = '0;
  logic        node_req = 1'b0;
  logic [9:0]  node_idx_reg = '0;
  logic        req_ready;
  logic        next_node_valid;
  logic        rd_next_node_reg = 1'b0;
  logic [9:0]  next_node_idx;
  logic [3:0]  next_node_counter;
  logic        node_empty;
  logic        load_drop;

  edge_list_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hdr_we           (hdr_we),
    .hdr_node         (hdr_node),
    .hdr_base         (hdr_base),
    .hdr_deg          (hdr_deg),
    .edge_we          (edge_we),
    .edge_addr        (edge_addr),
    .edge_succ        (edge_succ),
    .node_req         (node_req),
    .node_idx_reg     (node_idx_reg),
    .req_ready        (req_ready),
    .next_node_valid  (next_node_valid),
    .rd_next_node_reg (rd_next_node_reg),
    .next_node_idx    (next_node_idx),
    .next_node_counter(next_node_counter),
    .node_empty       (node_empty),
    .load_drop        (load_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int hdr_base_m [1024];
  int hdr_deg_m  [1024];
  int edge_m     [4096];
  int exp_idx [$];
  int exp_cnt [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stream checker: every presented successor must be the model's next one.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx.delete();
      exp_cnt.delete();
    end else if (next_node_valid) begin
      if (exp_idx.size() == 0) begin
        chk("stream_unexpected_valid", 1, 0);
      end else begin
        chk("stream_idx", int'(next_node_idx), exp_idx[0]);
        chk("stream_cnt", int'(next_node_counter), exp_cnt[0]);
        if (rd_next_node_reg) begin
          void'(exp_idx.pop_front());
          void'(exp_cnt.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hdr(input int n, input int base, input int deg);
    hdr_we = 1'b1;
    hdr_node = 10'(n);
    hdr_base = 12'(base);
    hdr_deg = 4'(deg);
    hdr_base_m[n] = base;
    hdr_deg_m[n] = deg;
    tick();
    hdr_we = 1'b0;
  endtask

  task automatic load_edge(input int a, input int s);
    edge_we = 1'b1;
    edge_addr = 12'(a);
    edge_succ = 10'(s);
    edge_m[a] = s;
    tick();
    edge_we = 1'b0;
  endtask

  task automatic req(input int n);
    int b;
    int d;
    b = hdr_base_m[n];
    d = hdr_deg_m[n];
    for (int k = 0; k < d; k++) begin
      exp_idx.push_back(edge_m[(b + k) % 4096]);
      exp_cnt.push_back(d - 1 - k);
    end
    node_req = 1'b1;
    node_idx_reg = 10'(n);
    tick();
    node_req = 1'b0;
  endtask

  task automatic drain(output int pops);
    int cyc;
    pops = 0;
    cyc = 0;
    while (!(req_ready && exp_idx.size() == 0) && cyc < 100) begin
      rd_next_node_reg = next_node_valid;
      if (next_node_valid) pops++;
      tick();
      cyc++;
    end
    rd_next_node_reg = 1'b0;
    chk("drain_timeout", cyc < 100 ? 0 : 1, 0);
  endtask

  initial begin
    int p;
    for (int i = 0; i < 1024; i++) begin
      hdr_base_m[i] = 0;
      hdr_deg_m[i] = 0;
    end
    for (int i = 0; i < 4096; i++) edge_m[i] = 0;

    tick();
    tick();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_valid", int'(next_node_valid), 0);
    chk("rst_idx", int'(next_node_idx), 0);
    chk("rst_cnt", int'(next_node_counter), 0);
    chk("rst_empty", int'(node_empty), 0);
    chk("rst_drop", int'(load_drop), 0);
    rst_n = 1'b1;
    tick();

    load_hdr(5, 100, 3);
    load_hdr(3, 0, 0);
    load_hdr(1, 4095, 2);
    load_edge(100, 7);
    load_edge(101, 9);
    load_edge(102, 11);
    load_edge(4095, 20);
    load_edge(0, 21);
    chk("load_no_drop", int'(load_drop), 0);

    // Node 5, consumer pops as soon as data is valid
    req(5);
    chk("n5_t1_ready", int'(req_ready), 0);
    chk("n5_t1_valid", int'(next_node_valid), 0);
    tick();
    chk("n5_t2_valid", int'(next_node_valid), 0);
    tick();
    chk("n5_t3_valid", int'(next_node_valid), 1);
    chk("n5_t3_idx", int'(next_node_idx), 7);
    chk("n5_t3_cnt", int'(next_node_counter), 2);
    rd_next_node_reg = 1'b1;
    tick();
    rd_next_node_reg = 1'b0;
    chk("n5_t4_valid", int'(next_node_valid), 0);
    tick();
    chk("n5_t5_valid", int'(next_node_valid), 1);
    chk("n5_t5_idx", int'(next_node_idx), 9);
    chk("n5_t5_cnt", int'(next_node_counter), 1);
    rd_next_node_reg = 1'b1;
    tick();
    rd_next_node_reg = 1'b0;
    tick();
    chk("n5_t7_idx", int'(next_node_idx), 11);
    chk("n5_t7_cnt", int'(next_node_counter), 0);
    rd_next_node_reg = 1'b1;
    tick();
    rd_next_node_reg = 1'b0;
    chk("n5_t8_valid", int'(next_node_valid), 0);
    chk("n5_t8_ready", int'(req_ready), 1);

    // Pop during FETCH, long backpressure, illegal request and write
    req(5);
    tick();
    rd_next_node_reg = 1'b1;
    tick();
    rd_next_node_reg = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", int'(next_node_valid), 1);
      chk("bp_idx", int'(next_node_idx), 7);
      chk("bp_cnt", int'(next_node_counter), 2);
      tick();
    end
    node_req = 1'b1;
    node_idx_reg = 10'd3;
    tick();
    node_req = 1'b0;
    chk("busy_req_ready", int'(req_ready), 0);
    tick();
    chk("busy_req_empty", int'(node_empty), 0);
    chk("busy_req_idx", int'(next_node_idx), 7);
    edge_we = 1'b1;
    edge_addr = 12'd101;
    edge_succ = 10'd99;
    tick();
    edge_we = 1'b0;
    chk("busy_write_drop", int'(load_drop), 1);
    drain(p);
    chk("bp_pops", p, 3);
    req(5);
    drain(p);
    chk("reexpand_pops", p, 3);
    chk("drop_sticky", int'(load_drop), 1);

    // Degree-0 node
    req(3);
    chk("d0_t1_empty", int'(node_empty), 0);
    chk("d0_t1_ready", int'(req_ready), 0);
    tick();
    chk("d0_t2_empty", int'(node_empty), 1);
    chk("d0_t2_ready", int'(req_ready), 1);
    chk("d0_t2_valid", int'(next_node_valid), 0);
    tick();
    chk("d0_t3_empty", int'(node_empty), 0);
    chk("d0_t3_valid", int'(next_node_valid), 0);

    // Edge pointer wrap
    req(1);
    tick();
    tick();
    chk("wrap_first_idx", int'(next_node_idx), 20);
    chk("wrap_first_cnt", int'(next_node_counter), 1);
    rd_next_node_reg = 1'b1;
    tick();
    rd_next_node_reg = 1'b0;
    tick();
    chk("wrap_second_idx", int'(next_node_idx), 21);
    chk("wrap_second_cnt", int'(next_node_counter), 0);
    drain(p);
    chk("wrap_pops", p, 1);

    // Reset while presenting
    req(5);
    tick();
    tick();
    chk("mid_valid_pre", int'(next_node_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", int'(next_node_valid), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_drop", int'(load_drop), 0);
    req(5);
    drain(p);
    chk("post_rst_pops", p, 3);
    chk("queue_empty", exp_idx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
